// File: rtl/bfly_pkg.sv
// Shared butterfly definitions: default widths, complex types and the
// reduction used when a wide result is squeezed back to DATA_W.
// Build option: IBFLY_SAT_EN selects saturation instead of wrap.
package bfly_pkg;

    localparam int DEF_DATA_W = 9;
    localparam int DEF_TW_W   = 9;
    localparam int RED_W      = 64;

    typedef struct packed {
        logic signed [DEF_DATA_W-1:0] re;
        logic signed [DEF_DATA_W-1:0] im;
    } cplx_t;

    typedef struct packed {
        logic signed [DEF_TW_W-1:0] re;
        logic signed [DEF_TW_W-1:0] im;
    } tw_t;

    // Largest value representable in a w-bit signed word.
    function automatic logic signed [RED_W-1:0] sat_hi(input int w);
        return (RED_W'(1) <<< (w - 1)) - RED_W'(1);
    endfunction

    // Smallest value representable in a w-bit signed word.
    function automatic logic signed [RED_W-1:0] sat_lo(input int w);
        return -(RED_W'(1) <<< (w - 1));
    endfunction

    // True when v does not fit in a w-bit signed word.
    function automatic logic saturates(input logic signed [RED_W-1:0] v, input int w);
        return (v > sat_hi(w)) || (v < sat_lo(w));
    endfunction

    // Reduce v to w significant bits, sign-extended back to RED_W.
    function automatic logic signed [RED_W-1:0] reduce(input logic signed [RED_W-1:0] v,
                                                       input int w);
`ifdef IBFLY_SAT_EN
        if (v > sat_hi(w)) return sat_hi(w);
        if (v < sat_lo(w)) return sat_lo(w);
        return v;
`else
        return (v <<< (RED_W - w)) >>> (RED_W - w);
`endif
    endfunction

endpackage

// File: rtl/ibfly2_pipe_cmul_conj.sv
// Combinational complex multiply d * conj(w), full-width signed result.
module cmul_conj #(
    parameter int D_W  = 10,
    parameter int TW_W = 9,
    parameter int P_W  = 19
) (
    input  logic signed [D_W-1:0]  d_re,
    input  logic signed [D_W-1:0]  d_im,
    input  logic signed [TW_W-1:0] w_re,
    input  logic signed [TW_W-1:0] w_im,
    output logic signed [P_W-1:0]  p_re,
    output logic signed [P_W-1:0]  p_im
);

    // (dr + j di)(wr - j wi) = (dr wr + di wi) + j (di wr - dr wi)
    always_comb begin
        p_re = P_W'(d_re) * P_W'(w_re) + P_W'(d_im) * P_W'(w_im);
        p_im = P_W'(d_im) * P_W'(w_re) - P_W'(d_re) * P_W'(w_im);
    end

endmodule

// File: rtl/ibfly2_pipe.sv
// Three-stage radix-2 inverse butterfly: a = (in0+in1)/2,
// b = conj(w)(in0-in1)/2, with a single global valid/ready advance.
// Build option: IBFLY_SAT_EN saturates the final reduction and adds ovf_flag.
module ibfly2_pipe
    import bfly_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TW_W    = DEF_TW_W,
    parameter int TW_FRAC = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in0r,
    input  logic signed [DATA_W-1:0] in0i,
    input  logic signed [DATA_W-1:0] in1r,
    input  logic signed [DATA_W-1:0] in1i,
    input  logic signed [TW_W-1:0]   wr,
    input  logic signed [TW_W-1:0]   wi,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] inr,
    output logic signed [DATA_W-1:0] ini,
    output logic signed [DATA_W-1:0] yr,
    output logic signed [DATA_W-1:0] yi
`ifdef IBFLY_SAT_EN
    ,
    output logic                     ovf_flag
`endif
);

    localparam int S_W  = DATA_W + 1;
    localparam int P_W  = DATA_W + TW_W + 1;
    localparam int Y_SH = TW_FRAC + 1;

    logic adv;

    logic                   s1_valid_q, s1_valid_d;
    logic signed [S_W-1:0]  s1_sr_q, s1_sr_d, s1_si_q, s1_si_d;
    logic signed [S_W-1:0]  s1_dr_q, s1_dr_d, s1_di_q, s1_di_d;
    logic signed [TW_W-1:0] s1_wr_q, s1_wr_d, s1_wi_q, s1_wi_d;

    logic                   s2_valid_q, s2_valid_d;
    logic signed [S_W-1:0]  s2_sr_q, s2_sr_d, s2_si_q, s2_si_d;
    logic signed [P_W-1:0]  s2_pr_q, s2_pr_d, s2_pi_q, s2_pi_d;

    logic                      s3_valid_q, s3_valid_d;
    logic signed [DATA_W-1:0]  inr_q, inr_d, ini_q, ini_d, yr_q, yr_d, yi_q, yi_d;

    logic signed [P_W-1:0]   prod_re, prod_im;
    logic signed [RED_W-1:0] a_re_w, a_im_w, b_re_w, b_im_w;

`ifdef IBFLY_SAT_EN
    logic ovf_q, ovf_d;
    assign ovf_flag = ovf_q;
`endif

    // A stalled output is the only thing that can freeze the pipe.
    assign adv       = out_ready | ~s3_valid_q;
    assign in_ready  = adv;
    assign out_valid = s3_valid_q;
    assign inr       = inr_q;
    assign ini       = ini_q;
    assign yr        = yr_q;
    assign yi        = yi_q;

    cmul_conj #(
        .D_W  (S_W),
        .TW_W (TW_W),
        .P_W  (P_W)
    ) u_cmul (
        .d_re (s1_dr_q),
        .d_im (s1_di_q),
        .w_re (s1_wr_q),
        .w_im (s1_wi_q),
        .p_re (prod_re),
        .p_im (prod_im)
    );

    // Next-state for every stage: hold by default, shift together on adv.
    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latch).
        s1_valid_d = s1_valid_q;
        s1_sr_d    = s1_sr_q;
        s1_si_d    = s1_si_q;
        s1_dr_d    = s1_dr_q;
        s1_di_d    = s1_di_q;
        s1_wr_d    = s1_wr_q;
        s1_wi_d    = s1_wi_q;
        s2_valid_d = s2_valid_q;
        s2_sr_d    = s2_sr_q;
        s2_si_d    = s2_si_q;
        s2_pr_d    = s2_pr_q;
        s2_pi_d    = s2_pi_q;
        s3_valid_d = s3_valid_q;
        inr_d      = inr_q;
        ini_d      = ini_q;
        yr_d       = yr_q;
        yi_d       = yi_q;
`ifdef IBFLY_SAT_EN
        ovf_d      = ovf_q;
`endif

        // Floor halving of the sums and floor scaling of the products.
        a_re_w = RED_W'(s2_sr_q >>> 1);
        a_im_w = RED_W'(s2_si_q >>> 1);
        b_re_w = RED_W'(s2_pr_q >>> Y_SH);
        b_im_w = RED_W'(s2_pi_q >>> Y_SH);

        if (adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_sr_d = S_W'(in0r) + S_W'(in1r);
                s1_si_d = S_W'(in0i) + S_W'(in1i);
                s1_dr_d = S_W'(in0r) - S_W'(in1r);
                s1_di_d = S_W'(in0i) - S_W'(in1i);
                s1_wr_d = wr;
                s1_wi_d = wi;
            end

            s2_valid_d = s1_valid_q;
            s2_sr_d    = s1_sr_q;
            s2_si_d    = s1_si_q;
            s2_pr_d    = prod_re;
            s2_pi_d    = prod_im;

            s3_valid_d = s2_valid_q;
            inr_d      = DATA_W'(reduce(a_re_w, DATA_W));
            ini_d      = DATA_W'(reduce(a_im_w, DATA_W));
            yr_d       = DATA_W'(reduce(b_re_w, DATA_W));
            yi_d       = DATA_W'(reduce(b_im_w, DATA_W));
`ifdef IBFLY_SAT_EN
            if (s2_valid_q && (saturates(a_re_w, DATA_W) || saturates(a_im_w, DATA_W) ||
                               saturates(b_re_w, DATA_W) || saturates(b_im_w, DATA_W)))
                ovf_d = 1'b1;
`endif
        end
    end

    // Control and output registers: cleared by synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: state is assigned with <= so all flops sample pre-edge values together.
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
            inr_q      <= '0;
            ini_q      <= '0;
            yr_q       <= '0;
            yi_q       <= '0;
`ifdef IBFLY_SAT_EN
            ovf_q      <= 1'b0;
`endif
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s3_valid_q <= s3_valid_d;
            inr_q      <= inr_d;
            ini_q      <= ini_d;
            yr_q       <= yr_d;
            yi_q       <= yi_d;
`ifdef IBFLY_SAT_EN
            ovf_q      <= ovf_d;
`endif
        end
    end

    // Internal stage data: qualified by the valid bits, so it needs no reset.
    always_ff @(posedge clk) begin
        // NOTE: datapath flops are left unreset; a cleared valid bit already makes them don't-care.
        s1_sr_q <= s1_sr_d;
        s1_si_q <= s1_si_d;
        s1_dr_q <= s1_dr_d;
        s1_di_q <= s1_di_d;
        s1_wr_q <= s1_wr_d;
        s1_wi_q <= s1_wi_d;
        s2_sr_q <= s2_sr_d;
        s2_si_q <= s2_si_d;
        s2_pr_q <= s2_pr_d;
        s2_pi_q <= s2_pi_d;
    end

endmodule

// File: tb/tb_ibfly2_pipe.sv
// Self-checking bench for ibfly2_pipe: directed scenarios plus a scoreboard
// fed at input acceptance and drained at output transfer.
// Build option: IBFLY_SAT_EN switches the expected reduction to saturation.
module tb_ibfly2_pipe;
    import bfly_pkg::*;

    localparam int DW   = 9;
    localparam int YDIV = 2;   // 2^(TW_FRAC+1) with TW_FRAC = 0

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, in_valid, in_ready, out_valid, out_ready;
    logic signed [DW-1:0] in0r, in0i, in1r, in1i, wr, wi;
    logic signed [DW-1:0] inr, ini, yr, yi;
`ifdef IBFLY_SAT_EN
    logic ovf_flag;
`endif

    ibfly2_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in0r      (in0r),
        .in0i      (in0i),
        .in1r      (in1r),
        .in1i      (in1i),
        .wr        (wr),
        .wi        (wi),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .inr       (inr),
        .ini       (ini),
        .yr        (yr),
        .yi        (yi)
`ifdef IBFLY_SAT_EN
        ,
        .ovf_flag  (ovf_flag)
`endif
    );

    typedef struct {
        cplx_t a;
        cplx_t b;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_recv   = 0;

    // Mathematical floor division by a positive divisor.
    function automatic int floor_div(input int x, input int d);
        int q;
        q = x / d;
        if ((x % d != 0) && (x < 0)) q = q - 1;
        return q;
    endfunction

    // Fit an integer into a 9-bit signed word (wrap or clamp).
    function automatic int fit(input int x);
        int r;
`ifdef IBFLY_SAT_EN
        if (x > 255) return 255;
        if (x < -256) return -256;
        return x;
`else
        r = x % 512;
        if (r < 0) r = r + 512;
        if (r >= 256) r = r - 512;
        return r;
`endif
    endfunction

    // Reference: a = floor((in0+in1)/2), b = floor(conj(w)(in0-in1)/2).
    function automatic exp_t model(input int a0r, a0i, a1r, a1i, w_r, w_i);
        exp_t e;
        int   dr, di, pr, pi;
        dr     = a0r - a1r;
        di     = a0i - a1i;
        pr     = dr * w_r + di * w_i;
        pi     = di * w_r - dr * w_i;
        e.a.re = 9'(fit(floor_div(a0r + a1r, 2)));
        e.a.im = 9'(fit(floor_div(a0i + a1i, 2)));
        e.b.re = 9'(fit(floor_div(pr, YDIV)));
        e.b.im = 9'(fit(floor_div(pi, YDIV)));
        return e;
    endfunction

    function automatic logic [35:0] pk4(input int a, b, c, d);
        return {9'(a), 9'(b), 9'(c), 9'(d)};
    endfunction

    // Scoreboard: push on accepted input, pop and compare on transferred output.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst) begin
            sb_q.delete();
        end else begin
            if (in_valid && in_ready)
                sb_q.push_back(model(in0r, in0i, in1r, in1i, wr, wi));
            if (out_valid && out_ready) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_underflow: got a=(%0d,%0d) b=(%0d,%0d), no output expected",
                             inr, ini, yr, yi);
                end else begin
                    e = sb_q.pop_front();
                    n_recv++;
                    if ({inr, ini, yr, yi} !== {e.a.re, e.a.im, e.b.re, e.b.im}) begin
                        n_fail++;
                        $display("FAIL sb_data: got a=(%0d,%0d) b=(%0d,%0d) expected a=(%0d,%0d) b=(%0d,%0d)",
                                 inr, ini, yr, yi, e.a.re, e.a.im, e.b.re, e.b.im);
                    end
                end
            end
        end
    end

    // Present one item and hold it until the edge that accepts it.
    task automatic send(input int a0r, a0i, a1r, a1i, w_r, w_i);
        bit acc;
        acc      = 1'b0;
        in0r     = 9'(a0r);
        in0i     = 9'(a0i);
        in1r     = 9'(a1r);
        in1i     = 9'(a1i);
        wr       = 9'(w_r);
        wi       = 9'(w_i);
        in_valid = 1'b1;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        n_checks++;
        if (!acc) begin
            n_fail++;
            $display("FAIL send_timeout: input not accepted within 50 cycles");
        end
    endtask

    // Count cycles from acceptance to out_valid and capture the output.
    task automatic wait_out(input string name, output logic [35:0] got);
        int lat;
        bit seen;
        lat  = 1;
        seen = 1'b0;
        got  = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                got  = {inr, ini, yr, yi};
                break;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (!seen || lat != 3) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d cycles (seen=%0d) expected 3", name, lat, seen);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        {in0r, in0i, in1r, in1i, wr, wi} = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++;
        if ({in_ready, out_valid, inr, ini, yr, yi} !== {1'b1, 1'b0, 36'd0}) begin
            n_fail++;
            $display("FAIL reset_hold: got ready=%0b valid=%0b a=(%0d,%0d) b=(%0d,%0d) expected 1 0 zeros",
                     in_ready, out_valid, inr, ini, yr, yi);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_release: got ready=%0b valid=%0b expected 1 0", in_ready, out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [35:0] got;
        send(10, 4, 6, -2, 1, 0);
        wait_out("basic", got);
        n_checks++;
        if (got !== pk4(8, 1, 2, 3)) begin
            n_fail++;
            $display("FAIL basic_value: got %h expected a=(8,1) b=(2,3) %h", got, pk4(8, 1, 2, 3));
        end
    endtask

    task automatic test_twiddle_j();
        logic [35:0] got;
        int ar, ai, br, bi;
        send(5, 7, 1, 3, 0, 1);
        wait_out("twj", got);
        ar = int'($signed(got[35:27]));
        ai = int'($signed(got[26:18]));
        br = int'($signed(got[17:9]));
        bi = int'($signed(got[8:0]));
        n_checks++;
        if (got !== pk4(3, 5, 2, -2)) begin
            n_fail++;
            $display("FAIL twj_value: got a=(%0d,%0d) b=(%0d,%0d) expected a=(3,5) b=(2,-2)", ar, ai, br, bi);
        end
        n_checks++;
        if ((ar - bi) != 5 || (ai + br) != 7) begin
            n_fail++;
            $display("FAIL twj_forward: got a+j*b=(%0d,%0d) expected (5,7)", ar - bi, ai + br);
        end
    endtask

    task automatic test_floor();
        logic [35:0] got;
        send(-3, 0, 0, 0, 1, 0);
        wait_out("floor_neg", got);
        n_checks++;
        if (got !== pk4(-2, 0, -2, 0)) begin
            n_fail++;
            $display("FAIL floor_neg: got %h expected a=(-2,0) b=(-2,0) %h", got, pk4(-2, 0, -2, 0));
        end
        send(3, 0, 0, 0, 1, 0);
        wait_out("floor_pos", got);
        n_checks++;
        if (got !== pk4(1, 0, 1, 0)) begin
            n_fail++;
            $display("FAIL floor_pos: got %h expected a=(1,0) b=(1,0) %h", got, pk4(1, 0, 1, 0));
        end
    endtask

    task automatic test_back_to_back();
        int n0;
        n0 = n_recv;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(int'($urandom_range(80)) - 40, int'($urandom_range(80)) - 40,
                         int'($urandom_range(80)) - 40, int'($urandom_range(80)) - 40,
                         int'($urandom_range(6)) - 3, int'($urandom_range(6)) - 3);
            end
            begin
                logic [36:0] snap;
                snap = '0;
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    n_checks++;
                    if ({out_valid, in_ready} !== 2'b10) begin
                        n_fail++;
                        $display("FAIL stall_ready: cycle %0d got valid=%0b ready=%0b expected 1 0",
                                 i + 4, out_valid, in_ready);
                    end
                    if (i == 0) begin
                        snap = {out_valid, inr, ini, yr, yi};
                    end else begin
                        n_checks++;
                        if ({out_valid, inr, ini, yr, yi} !== snap) begin
                            n_fail++;
                            $display("FAIL stall_stable: cycle %0d got %h expected %h",
                                     i + 4, {out_valid, inr, ini, yr, yi}, snap);
                        end
                    end
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        for (int k = 0; k < 30 && sb_q.size() != 0; k++) @(posedge clk);
        #1;
        n_checks++;
        if (n_recv - n0 != 8 || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d outputs (%0d pending) expected 8 (0 pending)",
                     n_recv - n0, sb_q.size());
        end
    endtask

    task automatic test_overflow();
        logic [35:0] got;
`ifdef IBFLY_SAT_EN
        n_checks++;
        if (ovf_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_pre: got ovf_flag=%0b expected 0", ovf_flag);
        end
`endif
        send(255, 0, -256, 0, 2, 0);
        wait_out("ovf", got);
`ifdef IBFLY_SAT_EN
        n_checks++;
        if (got !== pk4(-1, 0, 255, 0) || ovf_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sat: got %h ovf_flag=%0b expected %h ovf_flag=1", got, ovf_flag, pk4(-1, 0, 255, 0));
        end
`else
        n_checks++;
        if (got !== pk4(-1, 0, -1, 0)) begin
            n_fail++;
            $display("FAIL ovf_wrap: got %h expected a=(-1,0) b=(-1,0) %h", got, pk4(-1, 0, -1, 0));
        end
`endif
    endtask

    task automatic test_reset_mid();
        logic [35:0] got;
        send(1, 2, 3, 4, 1, 1);
        send(5, 6, 7, 8, 1, -1);
        send(9, 10, 11, 12, 2, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({in_ready, out_valid, inr, ini, yr, yi} !== {1'b1, 1'b0, 36'd0}) begin
            n_fail++;
            $display("FAIL rst_mid_flush: got ready=%0b valid=%0b a=(%0d,%0d) b=(%0d,%0d) expected 1 0 zeros",
                     in_ready, out_valid, inr, ini, yr, yi);
        end
        @(posedge clk);
        #1;
        send(20, -6, 4, 10, 1, 0);
        wait_out("rst_mid", got);
        n_checks++;
        if (got !== pk4(12, 2, 8, -8)) begin
            n_fail++;
            $display("FAIL rst_mid_value: got %h expected a=(12,2) b=(8,-8) %h", got, pk4(12, 2, 8, -8));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_twiddle_j();
        test_floor();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(posedge clk);
        #1;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d outputs still pending expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
